food_placer: RTL

- Consumer of the snake body position stream (per-clock pos_x/pos_y/first/last/valid beats, head first, tail last).
- Picks a pseudo-random free cell for the food and checks it against one complete body scan before publishing it.
- Detects the snake head entering the food cell and issues a single-cycle eat pulse back to the snake length logic.

---
 rtl/food_placer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/food_placer.sv
// Food placement for the snake game: draws LFSR candidates, validates each one
// against a full body scan before publishing it, and flags the head eating it.
module food_placer #(
  parameter int          GAME_WIDTH  = 30,
  parameter int          GAME_HEIGHT = 14,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic       i_success,
  output logic [4:0] o_food_x,
  output logic [3:0] o_food_y,
  output logic       o_food_valid,
  output logic       o_eat,
  output logic [7:0] o_attempts
);

  typedef enum logic [1:0] {
    ST_GEN,
    ST_WAIT,
    ST_SCAN,
    ST_PLACED
  } state_t;

  localparam logic [4:0] MAX_X = 5'(GAME_WIDTH);
  localparam logic [3:0] MAX_Y = 4'(GAME_HEIGHT);

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [4:0]  cand_x_q;
  logic [3:0]  cand_y_q;
  logic        hit_q;
  logic [4:0]  food_x_q;
  logic [3:0]  food_y_q;
  logic        food_valid_q;
  logic        eat_q;
  logic [7:0]  attempts_q;
  logic [7:0]  attempts_d;

  logic [4:0]  lfsr_x;
  logic [3:0]  lfsr_y;
  logic        lfsr_legal;
  logic        beat_match;
  logic        head_beat;
  logic        scan_done;
  logic        scan_hit;
  logic        food_head;

  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign lfsr_x     = lfsr_q[4:0];
  assign lfsr_y     = lfsr_q[8:5];
  assign lfsr_legal = (lfsr_x != 5'd0) && (lfsr_x <= MAX_X) &&
                      (lfsr_y != 4'd0) && (lfsr_y <= MAX_Y);

  assign beat_match = (i_pos_x == cand_x_q) && (i_pos_y == cand_y_q);
  assign head_beat  = i_pos_valid && i_pos_first;

  // A head beat restarts the scan, so prior hits only count mid-scan on non-head beats.
  assign scan_hit   = beat_match || (hit_q && !i_pos_first && (state_q == ST_SCAN));
  assign scan_done  = i_pos_valid && i_pos_last && ((state_q == ST_SCAN) || i_pos_first);
  assign food_head  = head_beat && (i_pos_x == food_x_q) && (i_pos_y == food_y_q);
  assign attempts_d = (attempts_q == 8'hFF) ? attempts_q : attempts_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_GEN;
      lfsr_q       <= LFSR_SEED;
      cand_x_q     <= 5'd0;
      cand_y_q     <= 4'd0;
      hit_q        <= 1'b0;
      food_x_q     <= 5'd0;
      food_y_q     <= 4'd0;
      food_valid_q <= 1'b0;
      eat_q        <= 1'b0;
      attempts_q   <= 8'd0;
    end else begin
      lfsr_q <= lfsr_d;
      eat_q  <= 1'b0;
      case (state_q)
        ST_GEN: begin
          food_valid_q <= 1'b0;
          if (!i_success && lfsr_legal) begin
            cand_x_q <= lfsr_x;
            cand_y_q <= lfsr_y;
            hit_q    <= 1'b0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT, ST_SCAN: begin
          if (scan_done) begin
            hit_q <= 1'b0;
            if (scan_hit) begin
              attempts_q <= attempts_d;
              state_q    <= ST_GEN;
            end else begin
              food_x_q     <= cand_x_q;
              food_y_q     <= cand_y_q;
              food_valid_q <= 1'b1;
              state_q      <= ST_PLACED;
            end
          end else if ((state_q == ST_SCAN) && !i_pos_valid) begin
            // Gap in the stream: this pass cannot prove the cell free.
            hit_q   <= 1'b0;
            state_q <= ST_WAIT;
          end else if ((state_q == ST_SCAN) || head_beat) begin
            hit_q   <= scan_hit;
            state_q <= ST_SCAN;
          end
        end
        ST_PLACED: begin
          if (i_success) begin
            food_valid_q <= 1'b0;
            state_q      <= ST_GEN;
          end else if (food_head) begin
            eat_q        <= 1'b1;
            food_valid_q <= 1'b0;
            attempts_q   <= 8'd0;
            state_q      <= ST_GEN;
          end
        end
        default: state_q <= ST_GEN;
      endcase
    end
  end

  assign o_food_x     = food_x_q;
  assign o_food_y     = food_y_q;
  assign o_food_valid = food_valid_q;
  assign o_eat        = eat_q;
  assign o_attempts   = attempts_q;

endmodule
